mul_sequencer: RTL and testbench

- Multi-cycle multiply controller for the single-cycle ARM core.
- Sequences an iterative shift-add multiplier over several clocks and stalls the core (PC and register write) until the product is ready.
- Returns a 2×WIDTH product as low/high words (MUL/UMULL), with N/Z flags.
- Sits beside the ALU/FPU in the datapath. The decoder raises start for a multiply encoding (bits [7:4] = 1001).

---
 rtl/mul_sequencer_if.sv | 34 +++
 rtl/mul_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: bundles the multiply request and result signals exchanged
// between the core's decode/writeback logic and mul_sequencer.
//   start      core -> seq  multiply instruction present (held while stalled)
//   a, b       core -> seq  multiplicand / multiplier
//   signed_op  core -> seq  signed multiply request
//   stall      seq -> core  hold PC, suppress register/memory/flag writes
//   done       seq -> core  one-cycle pulse, result valid this cycle
//   result_lo  seq -> core  product bits [WIDTH-1:0]
//   result_hi  seq -> core  product bits [2*WIDTH-1:WIDTH]
//   flags      seq -> core  {N,Z,C,V}
// master = core side, slave = sequencer side.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_op;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;

  modport master (
    output start, a, b, signed_op,
    input  stall, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, a, b, signed_op,
    output stall, done, result_lo, result_hi, flags
  );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiply controller for the
// single-cycle ARM core. Consumes STEP multiplier bits per RUN cycle,
// N = WIDTH/STEP RUN cycles, and stalls the core until the 2*WIDTH product
// is ready. Timeline: IDLE+start (cycle 0), RUN (1..N), DONE (N+1).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mul_sequencer_if.slave (start, a, b, signed_op -> stall, done,
//          result_lo, result_hi, flags)
//
// Parameters: WIDTH operand width; STEP bits per cycle (1, 2 or 4, must
// divide WIDTH).
//
// Optional feature: define MUL_SEQUENCER_SIGNED_EN to honour signed_op
// (magnitudes are multiplied and the product negated when the operand signs
// differ). Without it signed_op is ignored and every multiply is unsigned.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [3:0]       flags_q,  flags_d;
  logic             done_q,   done_d;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sign;

`ifndef MUL_SEQUENCER_SIGNED_EN
  logic             unused_signed_op;
`endif

  // Operand conditioning at acceptance time.
  always_comb begin
    op_a    = bus.a;
    op_b    = bus.b;
    op_sign = 1'b0;
`ifdef MUL_SEQUENCER_SIGNED_EN
    if (bus.signed_op) begin
      op_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
      op_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;
      op_sign = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
`else
    unused_signed_op = bus.signed_op;
`endif
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    // The multiplicand register is pre-shifted by STEP every RUN cycle, so it
    // always equals a << (count*STEP); no variable shifter is needed.
    pp = '0;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (mplier_q[j]) begin
        pp = pp + (mcand_q << j);
      end
    end
    sum  = acc_q + pp;
    prod = sign_q ? -sum : sum;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = PW'(op_a);
          mplier_d = op_b;
          sign_d   = op_sign;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          // Final partial product is folded in here, so the registered
          // result includes this cycle's contribution.
          state_d = DONE;
          lo_d    = prod[WIDTH-1:0];
          hi_d    = prod[PW-1:WIDTH];
          flags_d = {prod[PW-1], (prod == '0), 2'b00};
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // start is still high for the same instruction; ignore it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // stall is combinational so the core freezes in the accepting cycle; it is
  // forced low while reset is asserted so an abort releases the core at once.
  always_comb begin
    bus.stall     = !reset && (((state_q == IDLE) && bus.start) || (state_q == RUN));
    bus.done      = done_q;
    bus.result_lo = lo_q;
    bus.result_hi = hi_q;
    bus.flags     = flags_q;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam int N1 = 32;

  logic clk;
  logic reset;

  mul_sequencer_if #(.WIDTH(32)) bus  ();
  mul_sequencer_if #(.WIDTH(32)) bus4 ();

  mul_sequencer #(.WIDTH(32), .STEP(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mul_sequencer #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the STEP=1 instance: a request accepted at the
  // end of cycle t0 occupies the unit for cycles t0+1..t0+N1+1, with the
  // product appearing in cycle t0+N1+1.
  int          cyc = 0;
  int          t0 = 0;
  bit          busy = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_hi = '0;
  logic [3:0]  exp_fl = '0;
  longint      sa, sb;

  always @(posedge clk) begin
    if (reset) begin
      busy   = 0;
      exp_lo = '0;
      exp_hi = '0;
      exp_fl = '0;
    end else if (busy) begin
      if (cyc == t0 + N1) begin
        exp_lo = m_prod[31:0];
        exp_hi = m_prod[63:32];
        exp_fl = {m_prod[63], (m_prod == 64'd0), 2'b00};
      end
      if (cyc == t0 + N1 + 1) busy = 0;
    end else if (bus.start) begin
      busy   = 1;
      t0     = cyc;
      m_prod = {32'd0, bus.a} * {32'd0, bus.b};
`ifdef MUL_SEQUENCER_SIGNED_EN
      if (bus.signed_op) begin
        sa     = longint'($signed(bus.a));
        sb     = longint'($signed(bus.b));
        m_prod = sa * sb;
      end
`endif
    end
    cyc++;
  end

  always @(negedge clk) begin
    int  rel;
    bit  e_stall, e_done;
    if (reset) begin
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_done",  64'(bus.done), 64'd0);
      check("rst_lo",    64'(bus.result_lo), 64'd0);
      check("rst_hi",    64'(bus.result_hi), 64'd0);
      check("rst_flags", 64'(bus.flags), 64'd0);
    end else begin
      rel     = cyc - t0;
      e_stall = busy ? (rel >= 1 && rel <= N1) : bus.start;
      e_done  = busy && (rel == N1 + 1);
      check("m_stall", 64'(bus.stall), 64'(e_stall));
      check("m_done",  64'(bus.done), 64'(e_done));
      check("m_lo",    64'(bus.result_lo), 64'(exp_lo));
      check("m_hi",    64'(bus.result_hi), 64'(exp_hi));
      check("m_flags", 64'(bus.flags), 64'(exp_fl));
    end
  end

  task automatic set_req(input bit sel, input bit st, input logic [31:0] av,
                         input logic [31:0] bv, input bit sop);
    if (sel) begin
      bus4.start = st; bus4.a = av; bus4.b = bv; bus4.signed_op = sop;
    end else begin
      bus.start = st; bus.a = av; bus.b = bv; bus.signed_op = sop;
    end
  endtask

  // Called just after a rising edge; the current cycle is cycle 0 of the op.
  task automatic do_op(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                       input bit sop, input int lat, input logic [31:0] elo,
                       input logic [31:0] ehi, input logic [3:0] efl,
                       input bit hold, input int drop);
    int k;
    bit d, s;
    k = 0;
    d = 0;
    set_req(sel, 1'b1, av, bv, sop);
    while (1) begin
      @(negedge clk);
      d = sel ? bus4.done : bus.done;
      s = sel ? bus4.stall : bus.stall;
      if (d) break;
      check("busy_stall", 64'(s), 64'd1);
      k++;
      if (k > 200) break;
      if (drop != 0 && k == drop) begin
        @(posedge clk);
        #1;
        if (sel) bus4.start = 1'b0; else bus.start = 1'b0;
      end
    end
    check("latency", 64'(k), 64'(lat));
    if (d) begin
      check("done_stall", 64'(s), 64'd0);
      check("lit_lo", 64'(sel ? bus4.result_lo : bus.result_lo), 64'(elo));
      check("lit_hi", 64'(sel ? bus4.result_hi : bus.result_hi), 64'(ehi));
      check("lit_flags", 64'(sel ? bus4.flags : bus.flags), 64'(efl));
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) bus4.start = 1'b0; else bus.start = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_lo",    64'(bus.result_lo), 64'd0);
    check("reset_hi",    64'(bus.result_hi), 64'd0);
    check("reset_flags", 64'(bus.flags), 64'd0);
    check("reset_done",  64'(bus.done), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);
    check("reset4_lo",   64'(bus4.result_lo), 64'd0);
    @(posedge clk);
    #1;

    // STEP=1 directed vectors
    do_op(0, 32'd3, 32'd5, 0, 33, 32'h0000000F, 32'h0, 4'b0000, 0, 0);
    do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 0, 0);
    do_op(0, 32'd0, 32'h12345678, 0, 33, 32'h0, 32'h0, 4'b0100, 0, 0);
`ifdef MUL_SEQUENCER_SIGNED_EN
    do_op(0, 32'hFFFFFFFE, 32'd3, 1, 33, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000, 0, 0);
`else
    do_op(0, 32'hFFFFFFFE, 32'd3, 1, 33, 32'hFFFFFFFA, 32'h00000002, 4'b0000, 0, 0);
`endif
    // start dropped mid-RUN: operation still completes
    do_op(0, 32'h00012345, 32'h00000100, 0, 33, 32'h01234500, 32'h0, 4'b0000, 0, 5);
    // back-to-back: second request accepted in the cycle after DONE
    do_op(0, 32'd7, 32'd6, 0, 33, 32'd42, 32'h0, 4'b0000, 1, 0);
    do_op(0, 32'd2, 32'd9, 0, 33, 32'd18, 32'h0, 4'b0000, 0, 0);

    // reset in RUN cycle 10 aborts immediately
    set_req(0, 1'b1, 32'd7, 32'd6, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b0;
    #1;
    check("abort_stall", 64'(bus.stall), 64'd0);
    check("abort_done",  64'(bus.done), 64'd0);
    check("abort_lo",    64'(bus.result_lo), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    do_op(0, 32'h00010000, 32'h00010000, 0, 33, 32'h0, 32'h00000001, 4'b0000, 0, 0);

    // STEP=4 instance: 8 RUN cycles, done in cycle 9
    do_op(1, 32'd0, 32'h12345678, 0, 9, 32'h0, 32'h0, 4'b0100, 0, 0);
    do_op(1, 32'd3, 32'd5, 0, 9, 32'h0000000F, 32'h0, 4'b0000, 0, 0);
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 9, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 0, 0);
    do_op(1, 32'h89ABCDEF, 32'h00000010, 0, 9, 32'h9ABCDEF0, 32'h00000008, 4'b0000, 0, 0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
